// File: rtl/writeback_stage_if.sv
// Memory-to-writeback instruction handshake bundle.
// One instruction with its results and trap flags, valid/ready flow control.
interface writeback_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_next_pc;
    logic [31:0]     in_inst;
    logic            in_rd_en;
    logic [4:0]      in_rd_addr;
    logic [XLEN-1:0] in_rd_data;
    logic            in_csr_en;
    logic [11:0]     in_csr_addr;
    logic [XLEN-1:0] in_csr_data;
    logic            in_exc_valid;
    logic [5:0]      in_exc_code;
    logic            in_is_mret;
    logic            in_peripheral;

    modport master (
        output in_valid,
        output in_pc,
        output in_next_pc,
        output in_inst,
        output in_rd_en,
        output in_rd_addr,
        output in_rd_data,
        output in_csr_en,
        output in_csr_addr,
        output in_csr_data,
        output in_exc_valid,
        output in_exc_code,
        output in_is_mret,
        output in_peripheral,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_next_pc,
        input  in_inst,
        input  in_rd_en,
        input  in_rd_addr,
        input  in_rd_data,
        input  in_csr_en,
        input  in_csr_addr,
        input  in_csr_data,
        input  in_exc_valid,
        input  in_exc_code,
        input  in_is_mret,
        input  in_peripheral,
        output in_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one buffered instruction per cycle,
// resolves traps/mret at the boundary and holds a timed flush window.
module writeback_stage #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    writeback_stage_if.slave mem,
    input  logic             time_irq,
    input  logic             soft_irq,
    input  logic [XLEN-1:0]  csr_mtvec,
    input  logic [XLEN-1:0]  csr_mepc,
    output logic             wb_valid,
    output logic [4:0]       wb_dest_addr,
    output logic [XLEN-1:0]  wb_dest_data,
    output logic             csr_wb_valid,
    output logic [11:0]      csr_wb_addr,
    output logic [XLEN-1:0]  csr_wb_data,
    output logic             except_is_except,
    output logic             except_is_time_irq,
    output logic             except_is_soft_irq,
    output logic [5:0]       except_exception,
    output logic [XLEN-1:0]  except_pc,
    output logic [XLEN-1:0]  except_next_pc,
    output logic             commit,
    output logic [31:0]      difftest_inst,
    output logic             difftest_peripheral,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [31:0]     inst;
        logic            rd_en;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            csr_en;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
        logic            exc_valid;
        logic [5:0]      exc_code;
        logic            is_mret;
        logic            peripheral;
    } entry_t;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [5:0] CAUSE_TIME = 6'd7;
    localparam logic [5:0] CAUSE_SOFT = 6'd3;

    state_t          state_q, state_d;
    logic [2:0]      fcnt_q, fcnt_d;
    logic            full_q, full_d;
    entry_t          entry_q, entry_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    entry_t in_entry;
    logic   irq_take;
    logic   exc_take;
    logic   mret_take;
    logic   norm_take;
    logic   trap_take;
    logic   transfer;

    // Pack the incoming instruction into one entry record.
    always_comb begin
        in_entry            = '0;
        in_entry.pc         = mem.in_pc;
        in_entry.next_pc    = mem.in_next_pc;
        in_entry.inst       = mem.in_inst;
        in_entry.rd_en      = mem.in_rd_en;
        in_entry.rd_addr    = mem.in_rd_addr;
        in_entry.rd_data    = mem.in_rd_data;
        in_entry.csr_en     = mem.in_csr_en;
        in_entry.csr_addr   = mem.in_csr_addr;
        in_entry.csr_data   = mem.in_csr_data;
        in_entry.exc_valid  = mem.in_exc_valid;
        in_entry.exc_code   = mem.in_exc_code;
        in_entry.is_mret    = mem.in_is_mret;
        in_entry.peripheral = mem.in_peripheral;
    end

    // Retire class of the buffered entry: irq > exception > mret > normal.
    always_comb begin
        irq_take  = full_q & (time_irq | soft_irq);
        exc_take  = full_q & ~irq_take & entry_q.exc_valid;
        mret_take = full_q & ~irq_take & ~exc_take & entry_q.is_mret;
        norm_take = full_q & ~irq_take & ~exc_take & ~mret_take;
        trap_take = irq_take | exc_take | mret_take;
    end

    // A redirecting entry blocks the new instruction in its own cycle.
    always_comb begin
        mem.in_ready = (state_q == S_RUN) & ~trap_take;
        transfer     = mem.in_valid & mem.in_ready;
    end

    // Retire outputs, all gated to zero while the entry is empty.
    always_comb begin
        wb_valid            = norm_take & entry_q.rd_en &
                              (entry_q.rd_addr != 5'd0);
        wb_dest_addr        = full_q ? entry_q.rd_addr : 5'd0;
        wb_dest_data        = full_q ? entry_q.rd_data : '0;
        csr_wb_valid        = norm_take & entry_q.csr_en;
        csr_wb_addr         = full_q ? entry_q.csr_addr : 12'd0;
        csr_wb_data         = full_q ? entry_q.csr_data : '0;
        except_is_except    = irq_take | exc_take;
        except_is_time_irq  = irq_take & time_irq;
        except_is_soft_irq  = irq_take & soft_irq;
        except_exception    = 6'd0;
        if (irq_take) begin
            except_exception = time_irq ? CAUSE_TIME : CAUSE_SOFT;
        end else if (exc_take) begin
            except_exception = entry_q.exc_code;
        end
        except_pc           = full_q ? entry_q.pc : '0;
        except_next_pc      = full_q ? entry_q.next_pc : '0;
        commit              = full_q & ~irq_take;
        difftest_inst       = full_q ? entry_q.inst : 32'd0;
        difftest_peripheral = full_q & entry_q.peripheral;
        flush               = (state_q == S_FLUSH);
        redirect_pc         = redirect_pc_q;
    end

    // Next entry, FSM state, flush counter and redirect target.
    always_comb begin
        full_d        = transfer;
        entry_d       = transfer ? in_entry : '0;
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            S_RUN: begin
                if (trap_take) begin
                    state_d       = S_FLUSH;
                    fcnt_d        = FCNT_INIT;
                    redirect_pc_d = mret_take ? csr_mepc : csr_mtvec;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 3'd0) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            fcnt_q        <= 3'd0;
            full_q        <= 1'b0;
            entry_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            full_q        <= full_d;
            entry_q       <= entry_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against an instruction-level model,
// plus directed literal checks of writeback, traps, mret and reset.
module tb_writeback_stage;
    localparam int XLEN = 64;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [31:0] inst;
        bit          rd_en;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        bit          csr_en;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
        bit          exc_valid;
        logic [5:0]  exc_code;
        bit          is_mret;
        bit          peripheral;
    } instr_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    writeback_stage_if #(.XLEN(XLEN)) mif ();

    logic        time_irq, soft_irq;
    logic [63:0] csr_mtvec, csr_mepc;
    logic        wb_valid;
    logic [4:0]  wb_dest_addr;
    logic [63:0] wb_dest_data;
    logic        csr_wb_valid;
    logic [11:0] csr_wb_addr;
    logic [63:0] csr_wb_data;
    logic        except_is_except, except_is_time_irq, except_is_soft_irq;
    logic [5:0]  except_exception;
    logic [63:0] except_pc, except_next_pc;
    logic        commit;
    logic [31:0] difftest_inst;
    logic        difftest_peripheral;
    logic        flush;
    logic [63:0] redirect_pc;

    writeback_stage #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock(clock),
        .reset(reset),
        .mem(mif),
        .time_irq(time_irq),
        .soft_irq(soft_irq),
        .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc),
        .wb_valid(wb_valid),
        .wb_dest_addr(wb_dest_addr),
        .wb_dest_data(wb_dest_data),
        .csr_wb_valid(csr_wb_valid),
        .csr_wb_addr(csr_wb_addr),
        .csr_wb_data(csr_wb_data),
        .except_is_except(except_is_except),
        .except_is_time_irq(except_is_time_irq),
        .except_is_soft_irq(except_is_soft_irq),
        .except_exception(except_exception),
        .except_pc(except_pc),
        .except_next_pc(except_next_pc),
        .commit(commit),
        .difftest_inst(difftest_inst),
        .difftest_peripheral(difftest_peripheral),
        .flush(flush),
        .redirect_pc(redirect_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state: buffered instruction, remaining flush cycles, target
    bit          m_full;
    instr_t      m_e;
    int          m_flush_left;
    logic [63:0] m_rpc;
    instr_t      cur_in;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, {63'd0, act}, {63'd0, exp});
    endtask

    function automatic instr_t idle_instr();
        instr_t t;
        t.pc = 64'd0;
        t.next_pc = 64'd0;
        t.inst = 32'h0000_0013;
        t.rd_en = 1'b0;
        t.rd_addr = 5'd0;
        t.rd_data = 64'd0;
        t.csr_en = 1'b0;
        t.csr_addr = 12'd0;
        t.csr_data = 64'd0;
        t.exc_valid = 1'b0;
        t.exc_code = 6'd0;
        t.is_mret = 1'b0;
        t.peripheral = 1'b0;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.pc = {32'h0, $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
        t.next_pc = t.pc + 64'd4;
        t.inst = $urandom();
        t.rd_en = ($urandom_range(0, 3) != 0);
        t.rd_addr = 5'($urandom_range(0, 31));
        t.rd_data = {$urandom(), $urandom()};
        t.csr_en = ($urandom_range(0, 4) == 0);
        t.csr_addr = 12'($urandom());
        t.csr_data = {$urandom(), $urandom()};
        t.exc_valid = ($urandom_range(0, 9) == 0);
        t.exc_code = 6'($urandom_range(0, 15));
        t.is_mret = ($urandom_range(0, 11) == 0);
        t.peripheral = ($urandom_range(0, 1) == 1);
        return t;
    endfunction

    task automatic drive(instr_t t, bit v);
        cur_in = t;
        mif.in_valid = v;
        mif.in_pc = t.pc;
        mif.in_next_pc = t.next_pc;
        mif.in_inst = t.inst;
        mif.in_rd_en = t.rd_en;
        mif.in_rd_addr = t.rd_addr;
        mif.in_rd_data = t.rd_data;
        mif.in_csr_en = t.csr_en;
        mif.in_csr_addr = t.csr_addr;
        mif.in_csr_data = t.csr_data;
        mif.in_exc_valid = t.exc_valid;
        mif.in_exc_code = t.exc_code;
        mif.in_is_mret = t.is_mret;
        mif.in_peripheral = t.peripheral;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_e = idle_instr();
        m_flush_left = 0;
        m_rpc = 64'd0;
    endtask

    // Expected outputs from the retire rules; compare every field.
    task automatic model_check();
        bit irq, exc, mret, norm, trap;
        bit e_ready, e_wb, e_csr, e_exc;
        logic [5:0] e_code;
        irq  = m_full && (time_irq || soft_irq);
        exc  = m_full && !irq && m_e.exc_valid;
        mret = m_full && !irq && !exc && m_e.is_mret;
        norm = m_full && !irq && !exc && !mret;
        trap = irq || exc || mret;
        e_ready = (m_flush_left == 0) && !trap;
        e_wb  = norm && m_e.rd_en && (m_e.rd_addr != 5'd0);
        e_csr = norm && m_e.csr_en;
        e_exc = irq || exc;
        e_code = irq ? (time_irq ? 6'd7 : 6'd3) : m_e.exc_code;
        chk1("in_ready", mif.in_ready, e_ready);
        chk1("commit", commit, m_full && !irq);
        chk1("wb_valid", wb_valid, e_wb);
        if (e_wb) begin
            chk("wb_dest_addr", 64'(wb_dest_addr), 64'(m_e.rd_addr));
            chk("wb_dest_data", wb_dest_data, m_e.rd_data);
        end
        chk1("csr_wb_valid", csr_wb_valid, e_csr);
        if (e_csr) begin
            chk("csr_wb_addr", 64'(csr_wb_addr), 64'(m_e.csr_addr));
            chk("csr_wb_data", csr_wb_data, m_e.csr_data);
        end
        chk1("is_except", except_is_except, e_exc);
        chk1("is_time_irq", except_is_time_irq, irq && time_irq);
        chk1("is_soft_irq", except_is_soft_irq, irq && soft_irq);
        if (e_exc) begin
            chk("exception", 64'(except_exception), 64'(e_code));
        end
        chk("except_pc", except_pc, m_full ? m_e.pc : 64'd0);
        chk("except_next_pc", except_next_pc,
            m_full ? m_e.next_pc : 64'd0);
        chk("difftest_inst", 64'(difftest_inst),
            m_full ? 64'(m_e.inst) : 64'd0);
        chk1("difftest_periph", difftest_peripheral,
             m_full && m_e.peripheral);
        chk1("flush", flush, m_flush_left > 0);
        chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // Advance the model across one clock edge.
    task automatic model_update();
        bit irq, trap;
        irq  = m_full && (time_irq || soft_irq);
        trap = m_full && (irq || m_e.exc_valid || m_e.is_mret);
        if (m_flush_left > 0) begin
            m_flush_left--;
            m_full = 1'b0;
        end else if (trap) begin
            m_flush_left = FLUSH_CYCLES;
            m_rpc = (irq || m_e.exc_valid) ? csr_mtvec : csr_mepc;
            m_full = 1'b0;
        end else if (mif.in_valid) begin
            m_full = 1'b1;
            m_e = cur_in;
        end else begin
            m_full = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        model_check();
        model_update();
        @(posedge clock);
        #1;
    endtask

    initial begin
        instr_t t;
        int commits;
        reset = 1'b1;
        time_irq = 1'b0;
        soft_irq = 1'b0;
        csr_mtvec = 64'h8000_1000;
        csr_mepc = 64'd0;
        drive(idle_instr(), 1'b0);
        model_reset();
        #1;
        chk1("rst_commit", commit, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk("rst_redirect", redirect_pc, 64'd0);
        chk("rst_except_pc", except_pc, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk1("rel_in_ready", mif.in_ready, 1'b1);

        // normal writeback
        t = idle_instr();
        t.pc = 64'h8000_0000;
        t.next_pc = 64'h8000_0004;
        t.rd_en = 1'b1;
        t.rd_addr = 5'd5;
        t.rd_data = 64'h1234;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        chk1("norm_wb_valid", wb_valid, 1'b1);
        chk("norm_addr", 64'(wb_dest_addr), 64'd5);
        chk("norm_data", wb_dest_data, 64'h1234);
        chk1("norm_commit", commit, 1'b1);
        chk1("norm_ready", mif.in_ready, 1'b1);

        // back-to-back stream of four
        commits = 0;
        for (int i = 0; i < 4; i++) begin
            t = idle_instr();
            t.pc = 64'h8000_0100 + 64'(4 * i);
            t.next_pc = t.pc + 64'd4;
            t.rd_en = 1'b1;
            t.rd_addr = 5'(i + 1);
            t.rd_data = 64'(i);
            drive(t, 1'b1);
            step();
            commits += int'(commit);
        end
        chk("stream_commits", 64'(commits), 64'd4);

        // write to x0
        t = idle_instr();
        t.pc = 64'h8000_0008;
        t.rd_en = 1'b1;
        t.rd_addr = 5'd0;
        t.rd_data = 64'hdead;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        chk1("x0_wb_valid", wb_valid, 1'b0);
        chk1("x0_commit", commit, 1'b1);

        // exception with flush window
        csr_mtvec = 64'h8000_1000;
        t = idle_instr();
        t.pc = 64'h8000_0010;
        t.next_pc = 64'h8000_0014;
        t.exc_valid = 1'b1;
        t.exc_code = 6'd2;
        t.rd_en = 1'b1;
        t.rd_addr = 5'd7;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        chk1("exc_is_except", except_is_except, 1'b1);
        chk("exc_code", 64'(except_exception), 64'd2);
        chk1("exc_commit", commit, 1'b1);
        chk1("exc_wb_valid", wb_valid, 1'b0);
        chk1("exc_ready", mif.in_ready, 1'b0);
        step();
        t = idle_instr();
        t.pc = 64'h8000_1000;
        t.rd_en = 1'b1;
        t.rd_addr = 5'd3;
        drive(t, 1'b1);
        chk1("exc_flush1", flush, 1'b1);
        chk("exc_redirect", redirect_pc, 64'h8000_1000);
        chk1("exc_ready1", mif.in_ready, 1'b0);
        step();
        chk1("exc_flush2", flush, 1'b1);
        chk1("exc_ready2", mif.in_ready, 1'b0);
        step();
        chk1("exc_flush3", flush, 1'b0);
        chk1("exc_ready3", mif.in_ready, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        step();

        // timer + soft irq on an excepting entry
        t = idle_instr();
        t.pc = 64'h8000_0020;
        t.next_pc = 64'h8000_0024;
        t.exc_valid = 1'b1;
        t.exc_code = 6'd5;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        time_irq = 1'b1;
        soft_irq = 1'b1;
        #1;
        chk1("irq_time", except_is_time_irq, 1'b1);
        chk1("irq_soft", except_is_soft_irq, 1'b1);
        chk("irq_code", 64'(except_exception), 64'd7);
        chk1("irq_commit", commit, 1'b0);
        chk("irq_pc", except_pc, 64'h8000_0020);
        step();
        time_irq = 1'b0;
        soft_irq = 1'b0;
        chk("irq_redirect", redirect_pc, 64'h8000_1000);
        chk1("irq_flush", flush, 1'b1);
        step();
        step();

        // mret
        csr_mepc = 64'h8000_0040;
        t = idle_instr();
        t.pc = 64'h8000_0030;
        t.is_mret = 1'b1;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        chk1("mret_commit", commit, 1'b1);
        chk1("mret_except", except_is_except, 1'b0);
        step();
        chk1("mret_flush1", flush, 1'b1);
        chk("mret_redirect", redirect_pc, 64'h8000_0040);
        step();
        chk1("mret_flush2", flush, 1'b1);
        step();
        chk1("mret_flush3", flush, 1'b0);

        // reset asserted mid-flush
        t = idle_instr();
        t.pc = 64'h8000_0050;
        t.exc_valid = 1'b1;
        t.exc_code = 6'd4;
        drive(t, 1'b1);
        step();
        drive(idle_instr(), 1'b0);
        step();
        chk1("pre_rst_flush", flush, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("mid_rst_flush", flush, 1'b0);
        chk1("mid_rst_commit", commit, 1'b0);
        chk1("mid_rst_wb", wb_valid, 1'b0);
        chk("mid_rst_redirect", redirect_pc, 64'd0);
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk1("post_rst_ready", mif.in_ready, 1'b1);
        chk1("post_rst_flush", flush, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(rand_instr(), $urandom_range(0, 3) != 0);
            time_irq = ($urandom_range(0, 15) == 0);
            soft_irq = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) begin
                csr_mtvec = {$urandom(), $urandom()} & ~64'h3;
            end
            if ($urandom_range(0, 31) == 0) begin
                csr_mepc = {$urandom(), $urandom()} & ~64'h3;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; buffers one instruction from the memory stage.
- Generates the register-file writeback, CSR writeback, exception and interrupt, commit and difftest signals consumed by the commit/register-file block.
- Resolves traps and mret at the instruction boundary: it redirects fetch and holds a timed flush window before accepting new instructions.

Parameters:
- XLEN, 64, data/PC width.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect (min 1).

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: memory stage presents an instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_pc`, `in_next_pc` in XLEN: instruction PC; sequential/branch-resolved next PC.
- `in_inst` in 32: raw instruction.
- `in_rd_en` in 1, `in_rd_addr` in 5, `in_rd_data` in XLEN: GPR result.
- `in_csr_en` in 1, `in_csr_addr` in 12, `in_csr_data` in XLEN: CSR write.
- `in_exc_valid` in 1, `in_exc_code` in 6: synchronous exception.
- `in_is_mret` in 1: instruction is mret.
- `in_peripheral` in 1: instruction accessed MMIO.
- `time_irq`, `soft_irq` in 1: enabled, pending interrupts (already masked by mstatus.MIE/mie).
- `csr_mtvec`, `csr_mepc` in XLEN: current trap vector and return address.
- `wb_valid` out 1, `wb_dest_addr` out 5, `wb_dest_data` out XLEN: GPR write.
- `csr_wb_valid` out 1, `csr_wb_addr` out 12, `csr_wb_data` out XLEN: CSR write.
- `except_is_except`, `except_is_time_irq`, `except_is_soft_irq` out 1; `except_exception` out 6; `except_pc`, `except_next_pc` out XLEN: trap report.
- `commit` out 1: instruction retired this cycle.
- `difftest_inst` out 32, `difftest_peripheral` out 1.
- `flush` out 1, `redirect_pc` out XLEN: front-end kill and new fetch PC.

Behaviour:
- Storage and states:
  - One entry register (`full` flag plus all in_* fields).
  - FSM states: RUN and FLUSH. 3-bit down-counter `fcnt`.
- Reset (async, any time incl. mid-flush):
  - `full`=0, state=RUN, `fcnt`=0, all entry fields 0, `redirect_pc` register 0.
  - All outputs therefore 0.
- Handshake:
  - `in_ready` = (state==RUN) & !(full & trap_or_mret).
  - Transfer when `in_valid` & `in_ready`.
  - Entry drains unconditionally in the cycle it is full, so throughput is 1 instruction/cycle; latency is 1 cycle from accept to outputs.
  - If a transfer occurs, `full` is set next cycle; otherwise it clears.
- Retire decision, evaluated combinationally while `full`. Priority: irq > exception > mret > normal.
  - **irq** (`time_irq|soft_irq`):
    - `except_is_time_irq`/`except_is_soft_irq` mirror the inputs; `except_is_except`=1; `except_exception`=7 (time) or 3 (soft); time wins if both.
    - `commit`=0; GPR/CSR writes suppressed.
    - Redirect to `csr_mtvec`.
  - **exception**:
    - `except_is_except`=1, `except_exception`=`in_exc_code`, `commit`=1; GPR/CSR writes suppressed.
    - Redirect to `csr_mtvec`.
  - **mret**: `commit`=1, no except; redirect to `csr_mepc`.
  - **normal**:
    - `commit`=1.
    - `wb_valid`=`in_rd_en` & (`rd_addr`!=0).
    - `csr_wb_valid`=`in_csr_en`.
  - `except_pc`/`except_next_pc`, `difftest_inst` and `difftest_peripheral` are driven from the entry whenever `full`, and are 0 otherwise.
- Redirect:
  - On an irq, exception or mret retire, the redirect target is registered into `redirect_pc` and the FSM goes RUN->FLUSH with `fcnt`=FLUSH_CYCLES-1.
  - The entry is cleared; the input presented that cycle is not accepted.
  - In FLUSH: `flush`=1, `in_ready`=0, `redirect_pc` stable.
  - When `fcnt`==0 the FSM returns to RUN next cycle; otherwise `fcnt` decrements.
  - `flush`=0 in RUN.
- An interrupt asserted while in FLUSH or while the stage is empty is not taken; it is sampled only against a full entry.
- Output gating: every `*_valid`, `commit` and `except_*` flag is 0 when `full`=0.

Test Plan:
- Normal writeback: accept pc=0x80000000, rd=5, data=0x1234 -> next cycle `wb_valid`=1, `wb_dest_addr`=5, `wb_dest_data`=0x1234, `commit`=1, `in_ready` stays 1; back-to-back stream of 4 yields 4 consecutive commits.
- Write to x0: rd_en=1, rd_addr=0 -> `wb_valid`=0, `commit`=1.
- Exception:
  - Stimulus: exc_code=2 at pc=0x80000010, mtvec=0x80001000, with rd_en=1.
  - Response: `except_is_except`=1, `except_exception`=2, `commit`=1, `wb_valid`=0.
  - Following 2 cycles: `flush`=1, `redirect_pc`=0x80001000, `in_ready`=0. RUN resumes on cycle 4.
- Timer + soft irq with exception on the same entry:
  - Response: `except_is_time_irq`=1, `except_exception`=7, `commit`=0, `except_pc`=entry pc, redirect to mtvec.
- mret with mepc=0x80000040 -> `commit`=1, `except_is_except`=0, `flush` for 2 cycles, `redirect_pc`=0x80000040.
- Reset asserted mid-FLUSH (async, between clock edges) -> `flush`, `commit`, `wb_valid` drop to 0 immediately; after release, `in_ready`=1 and state=RUN.
